// File: rtl/pixel_readout_buffer_if.sv
// Pixel stream handshake between pixel_readout_buffer and its consumer.
// Master drives valid/data/last; slave drives ready.
interface pixel_readout_buffer_if #(
    parameter int ADC_W = 8
);
    logic             pix_valid;
    logic             pix_ready;
    logic [ADC_W-1:0] pix_data;
    logic             pix_last;

    modport master (
        output pix_valid,
        output pix_data,
        output pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        input  pix_last,
        output pix_ready
    );
endinterface

// File: rtl/pixel_readout_buffer.sv
// Two-row frame capture from the column ADCs, streamed out pixel by pixel.
// Optional PIXEL_FRAME_SUM_EN builds the per-frame pixel sum.
module pixel_readout_buffer #(
    parameter int ADC_W = 8,
    parameter int COLS  = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              nre1,
    input  logic                              nre2,
    input  logic                              adc,
    input  logic                              erase,
    input  logic [COLS*ADC_W-1:0]             adc_data,
    pixel_readout_buffer_if.master            pix,
    output logic [7:0]                        frame_count,
    output logic                              seq_err,
    output logic                              overrun,
    output logic [ADC_W+$clog2(2*COLS)-1:0]   frame_sum
);
    localparam int NPIX = 2 * COLS;
    localparam int IW   = $clog2(NPIX);
    localparam int SW   = ADC_W + $clog2(NPIX);
    localparam logic [IW-1:0] LAST_IDX = IW'(NPIX - 1);

    typedef enum logic [1:0] {
        EMPTY,
        HALF,
        FULL
    } state_e;

    state_e           state_q;
    logic [ADC_W-1:0] buf_q [NPIX];
    logic [IW-1:0]    idx_q;
    logic [IW-1:0]    nxt_idx;
    logic             valid_q;
    logic             last_q;
    logic [ADC_W-1:0] data_q;
    logic [7:0]       frame_q;
    logic             seq_q;
    logic             ovr_q;

    logic cap1;
    logic cap2;
    logic both;
    logic accept;

    assign cap1    = adc & ~nre1 & nre2;
    assign cap2    = adc & nre1 & ~nre2;
    assign both    = adc & ~nre1 & ~nre2;
    assign accept  = valid_q & pix.pix_ready;
    assign nxt_idx = idx_q + IW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            frame_q <= '0;
            seq_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (both)
                seq_q <= 1'b1;
            unique case (state_q)
                EMPTY: begin
                    if (cap1) begin
                        for (int c = 0; c < COLS; c++)
                            buf_q[c] <= adc_data[c*ADC_W +: ADC_W];
                        state_q <= HALF;
                    end else if (cap2) begin
                        seq_q <= 1'b1;
                    end
                end
                HALF: begin
                    if (cap1) begin
                        for (int c = 0; c < COLS; c++)
                            buf_q[c] <= adc_data[c*ADC_W +: ADC_W];
                    end else if (cap2) begin
                        for (int c = 0; c < COLS; c++)
                            buf_q[COLS+c] <= adc_data[c*ADC_W +: ADC_W];
                        state_q <= FULL;
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                        data_q  <= buf_q[0];
                        last_q  <= 1'b0;
                    end else if (erase) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    // Buffer is frozen while streaming; late rows are lost.
                    if (cap1 | cap2)
                        ovr_q <= 1'b1;
                    if (accept) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= EMPTY;
                            valid_q <= 1'b0;
                            data_q  <= '0;
                            last_q  <= 1'b0;
                            frame_q <= frame_q + 8'd1;
                        end else begin
                            idx_q  <= nxt_idx;
                            data_q <= buf_q[nxt_idx];
                            last_q <= (nxt_idx == LAST_IDX);
                        end
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign pix.pix_valid = valid_q;
    assign pix.pix_data  = data_q;
    assign pix.pix_last  = last_q;
    assign frame_count   = frame_q;
    assign seq_err       = seq_q;
    assign overrun       = ovr_q;

`ifdef PIXEL_FRAME_SUM_EN
    logic [SW-1:0] sum_q;
    logic [SW-1:0] sum_d;

    // Row 2 is summed straight off the bus since it lands in the buffer this edge.
    always_comb begin
        sum_d = '0;
        for (int c = 0; c < COLS; c++)
            sum_d = sum_d + SW'(buf_q[c]) + SW'(adc_data[c*ADC_W +: ADC_W]);
    end

    always_ff @(posedge clk) begin
        if (reset)
            sum_q <= '0;
        else if (state_q == HALF && cap2)
            sum_q <= sum_d;
    end

    assign frame_sum = sum_q;
`else
    assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_pixel_readout_buffer.sv
// Scoreboard bench for pixel_readout_buffer (ADC_W=8, COLS=2).
// Expected pixels are queued at row-2 capture and popped on each accept.
module tb_pixel_readout_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        nre1;
    logic        nre2;
    logic        adc;
    logic        erase;
    logic [15:0] adc_data;
    logic [7:0]  frame_count;
    logic        seq_err;
    logic        overrun;
    logic [9:0]  frame_sum;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;
    int k = 0;

    logic [8:0]  expq [$];
    logic        prev_stall = 1'b0;
    logic [8:0]  prev_pix;
    logic [31:0] exp_pix;

    always #5 clk = ~clk;

    pixel_readout_buffer_if #(.ADC_W(8)) pif ();

    pixel_readout_buffer #(
        .ADC_W(8),
        .COLS (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .nre1       (nre1),
        .nre2       (nre2),
        .adc        (adc),
        .erase      (erase),
        .adc_data   (adc_data),
        .pix        (pif.master),
        .frame_count(frame_count),
        .seq_err    (seq_err),
        .overrun    (overrun),
        .frame_sum  (frame_sum)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) begin
            pif.pix_ready = 1'b1;
        end else begin
            pif.pix_ready = (k % 4 == 0) || (k % 4 == 3);
            k++;
        end
    end

    // Monitor sits on the falling edge, between input updates and the next accept.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {23'd0, pif.pix_last, pif.pix_data},
                    {23'd0, prev_pix});
            if (pif.pix_valid && pif.pix_ready) begin
                exp_pix = (expq.size() == 0) ? 32'hDEAD
                                             : {23'd0, expq.pop_front()};
                chk("pixel", {23'd0, pif.pix_last, pif.pix_data}, exp_pix);
            end
            prev_stall = pif.pix_valid && !pif.pix_ready;
            prev_pix   = {pif.pix_last, pif.pix_data};
        end
    end

    task automatic cyc(input logic a, input logic n1, input logic n2,
                       input logic e, input logic [15:0] d);
        adc = a; nre1 = n1; nre2 = n2; erase = e; adc_data = d;
        @(posedge clk);
        #1;
        adc = 1'b0; nre1 = 1'b1; nre2 = 1'b1; erase = 1'b0;
    endtask

    task automatic row1(input logic [15:0] d);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, d);
    endtask

    task automatic row2(input logic [15:0] d);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, d);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    endtask

    task automatic push_frame(input logic [15:0] r1, input logic [15:0] r2);
        expq.push_back({1'b0, r1[7:0]});
        expq.push_back({1'b0, r1[15:8]});
        expq.push_back({1'b0, r2[7:0]});
        expq.push_back({1'b1, r2[15:8]});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rdy_mode = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        expq.delete();
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && expq.size() != 0; i++)
            @(posedge clk);
        @(posedge clk);
        #1;
        chk("drain_left", expq.size(), 0);
        chk("drain_valid", pif.pix_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [9:0] exp_sum;
`ifdef PIXEL_FRAME_SUM_EN
        exp_sum = 10'h0AA;
`else
        exp_sum = 10'h000;
`endif
        reset = 1'b1; adc = 1'b0; nre1 = 1'b1; nre2 = 1'b1;
        erase = 1'b0; adc_data = '0;
        do_reset();
        chk("rst_valid", pif.pix_valid, 1'b0);
        chk("rst_data", pif.pix_data, 8'h00);
        chk("rst_last", pif.pix_last, 1'b0);
        chk("rst_fc", frame_count, 8'd0);
        chk("rst_seq", seq_err, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
        chk("rst_sum", frame_sum, 10'd0);

        // basic frame at full rate
        row1(16'h2211);
        push_frame(16'h2211, 16'h4433);
        row2(16'h4433);
        chk("first_valid", pif.pix_valid, 1'b1);
        chk("first_data", pif.pix_data, 8'h11);
        chk("frame_sum", frame_sum, exp_sum);
        drain();
        chk("fc_1", frame_count, 8'd1);
        chk("sum_hold", frame_sum, exp_sum);

        // stalled frame
        rdy_mode = 1;
        k = 0;
        row1(16'h2211);
        push_frame(16'h2211, 16'h4433);
        row2(16'h4433);
        drain();
        rdy_mode = 0;
        chk("fc_2", frame_count, 8'd2);
        chk("no_ovr", overrun, 1'b0);

        // row 2 in EMPTY
        do_reset();
        row2(16'h5555);
        chk("r2_empty_seq", seq_err, 1'b1);
        chk("r2_empty_valid", pif.pix_valid, 1'b0);
        idle(2);
        chk("r2_empty_valid2", pif.pix_valid, 1'b0);

        // both nre low, then a normal frame proves EMPTY held
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h7777);
        chk("both_low_seq", seq_err, 1'b1);
        chk("both_low_valid", pif.pix_valid, 1'b0);
        row1(16'h0A09);
        push_frame(16'h0A09, 16'h0C0B);
        row2(16'h0C0B);
        drain();
        chk("after_both_fc", frame_count, 8'd1);

        // erase discards a half frame
        do_reset();
        row1(16'h2211);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h0);
        row2(16'h4433);
        chk("erase_seq", seq_err, 1'b1);
        idle(3);
        chk("erase_valid", pif.pix_valid, 1'b0);
        chk("erase_fc", frame_count, 8'd0);

        // overrun while streaming
        do_reset();
        row1(16'h0201);
        push_frame(16'h0201, 16'h0403);
        row2(16'h0403);
        row1(16'hFFFF);
        chk("overrun", overrun, 1'b1);
        drain();
        chk("ovr_fc", frame_count, 8'd1);
        chk("ovr_seq", seq_err, 1'b0);

        // reset mid-stream after two accepts
        do_reset();
        row1(16'h6655);
        push_frame(16'h6655, 16'h8877);
        row2(16'h8877);
        idle(2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", pif.pix_valid, 1'b0);
        chk("mid_rst_data", pif.pix_data, 8'h00);
        chk("mid_rst_last", pif.pix_last, 1'b0);
        chk("mid_rst_fc", frame_count, 8'd0);
        chk("mid_rst_sum", frame_sum, 10'd0);
        reset = 1'b0;
        expq.delete();
        row1(16'h2211);
        push_frame(16'h2211, 16'h4433);
        row2(16'h4433);
        drain();
        chk("post_rst_fc", frame_count, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pixel_readout_buffer.md
# pixel_readout_buffer

Captures the two pixel rows digitised by the column ADCs during the camera controller's convert phase and holds them as one frame. It then streams the frame out pixel by pixel over a valid/ready interface. The block sits directly downstream of the camera control FSM: it consumes that block's `nre1`, `nre2`, `adc` and `erase` outputs together with the parallel column ADC data bus.

## Interface
Parameters:
- `ADC_W`, default 8: bits per pixel sample.
- `COLS`, default 2: pixels per row. Rows are fixed at 2.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: synchronous, active-high.
- `nre1`, input, 1: row-1 read enable, active-low.
- `nre2`, input, 1: row-2 read enable, active-low.
- `adc`, input, 1: ADC sample strobe, active-high.
- `erase`, input, 1: pixel erase, high while the controller is idle.
- `adc_data`, input, `COLS*ADC_W`: column samples; column c occupies bits `[c*ADC_W +: ADC_W]`.
- `pix_ready`, input, 1: downstream accepts a pixel.
- `pix_valid`, output, 1: `pix_data` holds a valid pixel.
- `pix_data`, output, `ADC_W`: current pixel.
- `pix_last`, output, 1: current pixel is the last pixel of the frame.
- `frame_count`, output, 8: number of frames fully streamed; wraps from 255 to 0.
- `seq_err`, output, 1: sticky protocol-error flag.
- `overrun`, output, 1: sticky flag for a row dropped while streaming.
- `frame_sum`, output, `ADC_W+$clog2(2*COLS)`: sum of the frame's pixels (see Configuration).

## Operation
Row capture event on a clock edge:
- Row 1: `adc`=1, `nre1`=0, `nre2`=1.
- Row 2: `adc`=1, `nre2`=0, `nre1`=1.
- `adc`=1 with `nre1`=`nre2`=0: no capture; sets `seq_err`.

State machine:
- EMPTY
  - Row-1 capture: store row 1, go to HALF.
  - Row-2 capture: ignored, sets `seq_err`.
- HALF
  - Row-2 capture: store row 2, go to FULL. Pixel index = 0.
  - Row-1 capture: overwrites row 1, stays HALF.
  - `erase`=1 with no capture that edge: discard the partial frame, go to EMPTY.
- FULL (streaming): `pix_valid`=1.
  - Pixel order: row1 col0..COLS-1, then row2 col0..COLS-1.
  - `pix_valid`=1 and `pix_ready`=1 means the pixel is accepted; index advances.
  - Accepting the pixel at index `2*COLS-1`: go to EMPTY, `frame_count` +1.
  - Any row capture: dropped, sets `overrun`. Buffer contents are unchanged.
  - `erase` is ignored.
- `pix_data` and `pix_last` are held stable while `pix_valid`=1 and `pix_ready`=0.
- `pix_last`=1 only at index `2*COLS-1`.
- `seq_err` and `overrun` clear only on reset.

## Timing
Reset values: state EMPTY, `pix_valid`=0, `pix_data`=0, `pix_last`=0, `frame_count`=0, `seq_err`=0, `overrun`=0, `frame_sum`=0.

- Row-2 capture at edge N: `pix_valid`=1 and first pixel on `pix_data` from cycle N+1.
- One pixel per cycle while `pix_ready` is held 1. A 2x2 frame drains in 4 cycles.
- Final accept at edge M:
  - `pix_valid`=0 from cycle M+1.
  - A row-1 capture at edge M+1 is accepted.
  - A row-1 capture at edge M itself is an overrun, because the state is still FULL.
- Reset mid-stream: outputs return to reset values on the next edge. Buffer contents are don't-care.
- `adc` held high for several cycles with the same `nre` state: each cycle counts as a capture. Repeats on row 1 overwrite row 1.

## Configuration
`PIXEL_FRAME_SUM_EN`:
- Defined:
  - `frame_sum` is registered on the row-2 capture edge as row-1 sum plus row-2 sum.
  - It is valid from the first `pix_valid` cycle and holds until the next row-2 capture.
  - Full width; no overflow possible.
- Undefined: `frame_sum` is tied to 0 and no adder logic is built.

## Test plan
- `ADC_W`=8, `COLS`=2. Row-1 capture with data {0x22,0x11}, row-2 capture with {0x44,0x33}, `pix_ready`=1 -> `pix_data` 0x11, 0x22, 0x33, 0x44 on cycles N+1..N+4. `pix_last` only with 0x44. `frame_count`=1. With `PIXEL_FRAME_SUM_EN`, `frame_sum`=0xAA.
- Same frame with `pix_ready` toggling 1,0,0,1,... -> `pix_data` and `pix_last` stable while stalled. Exactly 4 accepts; no pixel duplicated or skipped.
- Row-2 capture in EMPTY, and separately `adc`=1 with both `nre` low -> `seq_err`=1, state remains EMPTY, `pix_valid`=0.
- Row-1 capture, then `erase`=1 one cycle, then row-2 capture -> no frame produced (`seq_err` set). `pix_valid` stays 0.
- During streaming, row-1 capture with 0xFF -> `overrun`=1; streamed pixels are still the original values.
- Reset asserted after 2 of 4 pixels are accepted -> all outputs at reset values next cycle. A following full frame streams correctly with `frame_count`=1.
